// File: rtl/out_port_serial_if.sv
// Bus bundle for out_port_serial: parallel load side plus the serial line and
// status outputs. The master drives WBUS/Lo, the slave (the port) drives the rest.
interface out_port_serial_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] WBUS;
   logic             Lo;
   logic             serial_out;
   logic             busy;
   logic             done;
   logic             acknowledge;
   logic             overrun;
   logic [WIDTH-1:0] data_hold;
   logic [1:0]       state_dbg;

   // Lo is a single-cycle strobe sampled on posedge CLK. It is accepted only
   // while busy=0, and that edge also captures WBUS. A Lo seen while busy=1
   // is dropped and raises overrun. done pulses once per finished frame.
   modport master (
      output WBUS, Lo,
      input  serial_out, busy, done, acknowledge, overrun, data_hold, state_dbg
   );

   modport slave (
      input  WBUS, Lo,
      output serial_out, busy, done, acknowledge, overrun, data_hold, state_dbg
   );
endinterface

// File: rtl/out_port_serial.sv
// Output port that frames a loaded word as an asynchronous serial stream:
// start bit, WIDTH data bits, STOP_BITS stop bits, BAUD_DIV clocks per bit.
module out_port_serial #(
   parameter int WIDTH     = 8,
   parameter int STOP_BITS = 1,
   parameter int BAUD_DIV  = 4,
   parameter int MSB_FIRST = 0
) (
   input logic              CLK,
   input logic              CLR,
   out_port_serial_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

   localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int CW = $clog2(WIDTH);
   localparam logic [TW-1:0] TIMER_LAST = TW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_BITS - 1);

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [TW-1:0]    timer;
   logic [CW-1:0]    bit_cnt;
   logic             bit_tick;
   logic             first_bit;
   logic             next_bit;
   logic [WIDTH-1:0] shifted;

   assign bus.state_dbg = state;

   // With BAUD_DIV=1 the timer stays at 0 and every cycle is a bit boundary.
   always_comb begin
      bit_tick  = (timer == TIMER_LAST);
      first_bit = 1'b0;
      next_bit  = 1'b0;
      shifted   = '0;
      if (MSB_FIRST != 0) begin
         first_bit = shreg[WIDTH-1];
         shifted   = shreg << 1;
         next_bit  = shifted[WIDTH-1];
      end else begin
         first_bit = shreg[0];
         shifted   = shreg >> 1;
         next_bit  = shifted[0];
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state           <= IDLE;
         shreg           <= '0;
         timer           <= '0;
         bit_cnt         <= '0;
         bus.serial_out  <= 1'b1;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.acknowledge <= 1'b0;
         bus.overrun     <= 1'b0;
         bus.data_hold   <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               bus.serial_out <= 1'b1;
               bus.busy       <= 1'b0;
               timer          <= '0;
               bit_cnt        <= '0;
               if (bus.Lo) begin
                  shreg           <= bus.WBUS;
                  bus.data_hold   <= bus.WBUS;
                  bus.acknowledge <= 1'b0;
                  bus.overrun     <= 1'b0;
                  bus.serial_out  <= 1'b0;
                  bus.busy        <= 1'b1;
                  state           <= START;
               end
            end
            default: begin
               // Any load while a frame is in flight, including its last stop cycle, is an overrun.
               if (bus.Lo) bus.overrun <= 1'b1;
               timer <= bit_tick ? '0 : timer + TW'(1);
               if (bit_tick) begin
                  case (state)
                     START: begin
                        state          <= DATA;
                        bus.serial_out <= first_bit;
                        bit_cnt        <= '0;
                     end
                     DATA: begin
                        if (bit_cnt == BIT_LAST) begin
                           state          <= STOP;
                           bus.serial_out <= 1'b1;
                           bit_cnt        <= '0;
                        end else begin
                           shreg          <= shifted;
                           bus.serial_out <= next_bit;
                           bit_cnt        <= bit_cnt + CW'(1);
                        end
                     end
                     STOP: begin
                        if (bit_cnt == STOP_LAST) begin
                           state           <= IDLE;
                           bus.done        <= 1'b1;
                           bus.acknowledge <= 1'b1;
                           bus.busy        <= 1'b0;
                           bit_cnt         <= '0;
                        end else begin
                           bit_cnt <= bit_cnt + CW'(1);
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end
endmodule
